// File: rtl/akiko_pkg.sv
// Shared definitions for the Akiko chunky/planar converter.
//   akiko_state_e : converter sequencing states
//   REG_*         : register offsets, matched against address_in[7:2]
//   MODE_*        : conversion direction held in CTRL bit 0
//   CTRL_*_BIT    : bit positions inside the CTRL register
package akiko_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } akiko_state_e;

  localparam logic [5:0] REG_DATA = 6'b001110;  // $B80038 / $B8003A
  localparam logic [5:0] REG_CTRL = 6'b001100;  // $B80030 / $B80032

  localparam logic MODE_C2P = 1'b0;
  localparam logic MODE_P2C = 1'b1;

  localparam int CTRL_MODE_BIT  = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_FILL_BIT  = 8;
  localparam int CTRL_DRAIN_BIT = 9;
  localparam int CTRL_FULL_BIT  = 10;

endpackage

// File: rtl/akiko_xpose_mux.sv
// Combinational read-word selector for the converter bit matrix.
// Ports:
//   bits  : flattened matrix, bit index = pixel*PLANES + plane
//   mode  : MODE_C2P reads planar words, MODE_P2C reads chunky words
//   rdptr : word index within the block
//   word  : selected DATA_W-bit read word
// PLANES must divide DATA_W so that whole pixels pack into one chunky word.
module akiko_xpose_mux
  import akiko_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PIXELS = 16,
  parameter int PLANES = 8,
  parameter int PTR_W  = 4
) (
  input  logic [PIXELS*PLANES-1:0] bits,
  input  logic                     mode,
  input  logic [PTR_W-1:0]         rdptr,
  output logic [DATA_W-1:0]        word
);

  localparam int WORDS  = PIXELS * PLANES / DATA_W;
  localparam int PPW    = DATA_W / PLANES;   // pixels per chunky word
  localparam int GROUPS = PIXELS / DATA_W;   // planar words per plane
  localparam int DEPTH  = 1 << PTR_W;

  // Padded to the full pointer range so the final select needs no range check.
  logic [DATA_W-1:0] word_tbl [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    if (k < WORDS) begin : g_live
      logic [DATA_W-1:0] c2p_w;
      logic [DATA_W-1:0] p2c_w;

      // Planar word k: plane k/GROUPS, leftmost pixel in the MSB.
      for (genvar i = 0; i < DATA_W; i++) begin : g_planar
        assign c2p_w[DATA_W-1-i] = bits[((k % GROUPS) * DATA_W + i) * PLANES + k / GROUPS];
      end

      // Chunky word k: first pixel in the top field, plane 0 at the field LSB.
      for (genvar j = 0; j < PPW; j++) begin : g_chunk_px
        for (genvar p = 0; p < PLANES; p++) begin : g_chunk_pl
          assign p2c_w[DATA_W-(j+1)*PLANES+p] = bits[(k * PPW + j) * PLANES + p];
        end
      end

      assign word_tbl[k] = (mode == MODE_P2C) ? p2c_w : c2p_w;
    end else begin : g_pad
      assign word_tbl[k] = '0;
    end
  end

  assign word = word_tbl[rdptr];

endmodule

// File: rtl/akiko_c2p_ext.sv
// Akiko chunky-to-planar / planar-to-chunky converter on the $B8 register bus.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   address_in   : CPU word address [23:1]
//   data_in      : write data
//   data_out     : read data, 0 unless a DATA/CTRL read is in progress
//   rd           : one-clock read strobe
//   hwr, lwr     : one-clock byte-lane write strobes (both needed for a write)
//   sel_akiko    : $B8xxxx decode
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no block in flight; pointers at 0
// ST_FILL  | accepting block words at wrptr (held once wrptr == W)
// ST_DRAIN | returning transposed words at rdptr; W-th read ends block
module akiko_c2p_ext
  import akiko_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PIXELS = 16,
  parameter int PLANES = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [23:1]       address_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              rd,
  input  logic              hwr,
  input  logic              lwr,
  input  logic              sel_akiko
);

  localparam int WORDS  = PIXELS * PLANES / DATA_W;
  localparam int PTR_W  = $clog2(WORDS + 1);
  localparam int PPW    = DATA_W / PLANES;
  localparam int GROUPS = PIXELS / DATA_W;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORDS - 1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(WORDS);

  akiko_state_e              state;
  logic [PTR_W-1:0]          wrptr;
  logic [PTR_W-1:0]          rdptr;
  logic                      mode;
  logic [PIXELS*PLANES-1:0]  bits_q;
  logic [PIXELS*PLANES-1:0]  bits_d;

  logic sel_data, sel_ctrl, wr_both;
  logic data_wr, data_rd, ctrl_wr, ctrl_rd;
  logic store;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic              ctrl_new_mode;
  logic              ctrl_abort;

  logic unused_addr;
  assign unused_addr = ^{address_in[23:8], address_in[1]};

  assign sel_data = sel_akiko && (address_in[7:2] == REG_DATA);
  assign sel_ctrl = sel_akiko && (address_in[7:2] == REG_CTRL);
  assign wr_both  = hwr && lwr;
  assign data_wr  = sel_data && wr_both;
  assign data_rd  = sel_data && rd;
  assign ctrl_wr  = sel_ctrl && wr_both;
  assign ctrl_rd  = sel_ctrl && rd;

  assign ctrl_new_mode = data_in[CTRL_MODE_BIT];
  assign ctrl_abort    = data_in[CTRL_ABORT_BIT] ||
                         ((ctrl_new_mode != mode) && (state != ST_IDLE));

  // IDLE and DRAIN both restart the block at word 0; a full FILL drops writes.
  assign store  = data_wr && !((state == ST_FILL) && (wrptr == PTR_FULL));
  assign wr_idx = (state == ST_FILL) ? wrptr : '0;
  assign rd_idx = (state == ST_DRAIN) ? rdptr : '0;

  // Each matrix bit knows statically which word and which data_in bit feeds it
  // in either direction, so the write path is a per-bit compare and mux.
  for (genvar px = 0; px < PIXELS; px++) begin : g_pix
    for (genvar pl = 0; pl < PLANES; pl++) begin : g_pl
      localparam int IDX = px * PLANES + pl;
      localparam logic [PTR_W-1:0] K_C2P = PTR_W'(px / PPW);
      localparam logic [PTR_W-1:0] K_P2C = PTR_W'(pl * GROUPS + px / DATA_W);
      localparam int SRC_C2P = DATA_W - ((px % PPW) + 1) * PLANES + pl;
      localparam int SRC_P2C = DATA_W - 1 - (px % DATA_W);
      logic hit;

      assign hit = store && ((mode == MODE_C2P) ? (wr_idx == K_C2P) : (wr_idx == K_P2C));
      assign bits_d[IDX] = hit ? ((mode == MODE_C2P) ? data_in[SRC_C2P] : data_in[SRC_P2C])
                               : bits_q[IDX];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      wrptr <= '0;
      rdptr <= '0;
      mode  <= MODE_C2P;
    end else if (ctrl_wr) begin
      mode <= ctrl_new_mode;
      if (ctrl_abort) begin
        state <= ST_IDLE;
        wrptr <= '0;
        rdptr <= '0;
      end
    end else if (data_wr) begin
      // A write in the same cycle as rd wins; the read only shows on data_out.
      case (state)
        ST_IDLE: begin
          wrptr <= PTR_ONE;
          state <= ST_FILL;
        end
        ST_FILL: begin
          if (wrptr != PTR_FULL) begin
            wrptr <= wrptr + PTR_ONE;
          end
        end
        ST_DRAIN: begin
          rdptr <= '0;
          wrptr <= PTR_ONE;
          state <= ST_FILL;
        end
        default: begin
          state <= ST_IDLE;
          wrptr <= '0;
          rdptr <= '0;
        end
      endcase
    end else if (data_rd) begin
      case (state)
        ST_IDLE, ST_FILL: begin
          wrptr <= '0;
          if (WORDS == 1) begin
            rdptr <= '0;
            state <= ST_IDLE;
          end else begin
            rdptr <= PTR_ONE;
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (rdptr == PTR_LAST) begin
            rdptr <= '0;
            state <= ST_IDLE;
          end else begin
            rdptr <= rdptr + PTR_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          wrptr <= '0;
          rdptr <= '0;
        end
      endcase
    end
  end

  akiko_xpose_mux #(
    .DATA_W (DATA_W),
    .PIXELS (PIXELS),
    .PLANES (PLANES),
    .PTR_W  (PTR_W)
  ) u_xpose_mux (
    .bits  (bits_q),
    .mode  (mode),
    .rdptr (rd_idx),
    .word  (rd_word)
  );

  // Read data is combinational in the rd cycle so the CPU sees it without a wait state.
  always_comb begin
    data_out = '0;
    if (reset_n) begin
      if (data_rd) begin
        data_out = rd_word;
      end else if (ctrl_rd) begin
        data_out[CTRL_MODE_BIT]  = mode;
        data_out[CTRL_FILL_BIT]  = (state == ST_FILL);
        data_out[CTRL_DRAIN_BIT] = (state == ST_DRAIN);
        data_out[CTRL_FULL_BIT]  = (wrptr == PTR_FULL);
      end
    end
  end

endmodule

// File: tb/tb_akiko_c2p_ext.sv
// Bench for akiko_c2p_ext: three instances (16/16, 32/32, 16-bit bus with 32 pixels)
// share one bus; a pixel/plane image model predicts every read.
module tb_akiko_c2p_ext;

  localparam logic [23:0] A_DATA  = 24'hB80038;
  localparam logic [23:0] A_DATA2 = 24'hB8003A;
  localparam logic [23:0] A_CTRL  = 24'hB80030;
  localparam logic [23:0] A_OTHER = 24'hB80034;
  localparam int NI = 3;
  localparam int PH_IDLE  = 0;
  localparam int PH_FILL  = 1;
  localparam int PH_DRAIN = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:1] addr;
  logic [31:0] din;
  logic        rd, hwr, lwr;
  logic [2:0]  sel;
  logic [15:0] dout0;
  logic [31:0] dout1;
  logic [15:0] dout2;

  always #5 clk = ~clk;

  akiko_c2p_ext #(.DATA_W(16), .PIXELS(16), .PLANES(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .address_in(addr), .data_in(din[15:0]),
    .data_out(dout0), .rd(rd), .hwr(hwr), .lwr(lwr), .sel_akiko(sel[0]));

  akiko_c2p_ext #(.DATA_W(32), .PIXELS(32), .PLANES(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .address_in(addr), .data_in(din),
    .data_out(dout1), .rd(rd), .hwr(hwr), .lwr(lwr), .sel_akiko(sel[1]));

  akiko_c2p_ext #(.DATA_W(16), .PIXELS(32), .PLANES(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .address_in(addr), .data_in(din[15:0]),
    .data_out(dout2), .rd(rd), .hwr(hwr), .lwr(lwr), .sel_akiko(sel[2]));

  int n_cmp = 0;
  int n_err = 0;

  // Reference: image[pixel][plane] plus block progress per instance.
  bit img [NI][64][8];
  int m_mode  [NI];
  int m_phase [NI];
  int m_wp    [NI];
  int m_rp    [NI];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int dw_of(input int w);
    return (w == 1) ? 32 : 16;
  endfunction

  function automatic int pix_of(input int w);
    return (w == 0) ? 16 : 32;
  endfunction

  function automatic int words_of(input int w);
    return pix_of(w) * 8 / dw_of(w);
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < NI; w++) begin
      for (int x = 0; x < 64; x++)
        for (int p = 0; p < 8; p++) img[w][x][p] = 1'b0;
      m_mode[w] = 0; m_phase[w] = PH_IDLE; m_wp[w] = 0; m_rp[w] = 0;
    end
  endfunction

  function automatic void model_store(input int w, input int k, input logic [31:0] d);
    int dw, groups;
    dw = dw_of(w);
    groups = pix_of(w) / dw;
    if (m_mode[w] == 0) begin
      for (int j = 0; j < dw / 8; j++)
        for (int p = 0; p < 8; p++) img[w][k * (dw / 8) + j][p] = d[dw - 8 * (j + 1) + p];
    end else begin
      for (int i = 0; i < dw; i++) img[w][(k % groups) * dw + i][k / groups] = d[dw - 1 - i];
    end
  endfunction

  function automatic logic [31:0] model_word(input int w, input int r);
    logic [31:0] q;
    int dw, groups;
    q = '0;
    dw = dw_of(w);
    groups = pix_of(w) / dw;
    if (m_mode[w] == 0) begin
      for (int i = 0; i < dw; i++) q[dw - 1 - i] = img[w][(r % groups) * dw + i][r / groups];
    end else begin
      for (int j = 0; j < dw / 8; j++)
        for (int p = 0; p < 8; p++) q[dw - 8 * (j + 1) + p] = img[w][r * (dw / 8) + j][p];
    end
    return q;
  endfunction

  function automatic void model_write(input int w, input logic [31:0] d);
    if (m_phase[w] == PH_FILL) begin
      if (m_wp[w] < words_of(w)) begin
        model_store(w, m_wp[w], d);
        m_wp[w]++;
      end
    end else begin
      model_store(w, 0, d);
      m_wp[w] = 1; m_rp[w] = 0; m_phase[w] = PH_FILL;
    end
  endfunction

  function automatic logic [31:0] model_read_exp(input int w);
    return model_word(w, (m_phase[w] == PH_DRAIN) ? m_rp[w] : 0);
  endfunction

  function automatic void model_read_adv(input int w);
    if (m_phase[w] != PH_DRAIN) begin
      m_wp[w] = 0; m_rp[w] = 1; m_phase[w] = PH_DRAIN;
    end else begin
      m_rp[w]++;
      if (m_rp[w] == words_of(w)) begin
        m_rp[w] = 0; m_phase[w] = PH_IDLE;
      end
    end
  endfunction

  function automatic logic [31:0] model_ctrl(input int w);
    logic [31:0] q;
    q = '0;
    q[0]  = (m_mode[w] != 0);
    q[8]  = (m_phase[w] == PH_FILL);
    q[9]  = (m_phase[w] == PH_DRAIN);
    q[10] = (m_wp[w] == words_of(w));
    return q;
  endfunction

  function automatic logic [31:0] fit(input int w, input logic [31:0] d);
    return (dw_of(w) == 16) ? {16'h0, d[15:0]} : d;
  endfunction

  task automatic bus_op(input int w, input logic [23:0] a, input logic s, input logic r,
                        input logic h, input logic l, input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    addr = a[23:1]; din = d; rd = r; hwr = h; lwr = l;
    sel = '0;
    if (s) sel[w] = 1'b1;
    #1;
    q = (w == 0) ? {16'h0, dout0} : (w == 1) ? dout1 : {16'h0, dout2};
    @(posedge clk);
    #1;
    rd = 1'b0; hwr = 1'b0; lwr = 1'b0; sel = '0;
  endtask

  task automatic data_write(input int w, input logic [31:0] d);
    logic [31:0] q;
    logic [31:0] dd;
    dd = fit(w, d);
    bus_op(w, ($urandom_range(0, 1) != 0) ? A_DATA : A_DATA2, 1'b1, 1'b0, 1'b1, 1'b1, dd, q);
    model_write(w, dd);
  endtask

  task automatic data_read(input int w, input string tag, output logic [31:0] got);
    logic [31:0] exp;
    exp = model_read_exp(w);
    bus_op(w, A_DATA, 1'b1, 1'b1, 1'b0, 1'b0, '0, got);
    check_val(tag, got, exp);
    model_read_adv(w);
  endtask

  task automatic ctrl_write(input int w, input logic [31:0] d);
    logic [31:0] q;
    bus_op(w, A_CTRL, 1'b1, 1'b0, 1'b1, 1'b1, d, q);
    if (d[1] || ((int'(d[0]) != m_mode[w]) && (m_phase[w] != PH_IDLE))) begin
      m_phase[w] = PH_IDLE; m_wp[w] = 0; m_rp[w] = 0;
    end
    m_mode[w] = int'(d[0]);
  endtask

  task automatic ctrl_read(input int w, input string tag, output logic [31:0] got);
    bus_op(w, A_CTRL, 1'b1, 1'b1, 1'b0, 1'b0, '0, got);
    check_val(tag, got, model_ctrl(w));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] q;
    reset_n = 1'b0;
    addr = '0; din = '0; rd = 1'b0; hwr = 1'b0; lwr = 1'b0; sel = '0;
    model_reset();
    #22 reset_n = 1'b1;

    ctrl_read(0, "reset_ctrl", q);
    check_val("reset_ctrl_const", q, 32'h0);

    // C2P: plane 0 set on every pixel
    for (int k = 0; k < 8; k++) data_write(0, 32'h0101);
    for (int k = 0; k < 8; k++) begin
      data_read(0, "c2p_p0", q);
      check_val("c2p_p0_const", q, (k == 0) ? 32'hFFFF : 32'h0);
    end
    ctrl_read(0, "c2p_p0_idle", q);
    check_val("c2p_p0_idle_const", q, 32'h0);

    // C2P: pixel 0 all planes
    data_write(0, 32'hFF00);
    for (int k = 1; k < 8; k++) data_write(0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      data_read(0, "c2p_px0", q);
      check_val("c2p_px0_const", q, 32'h8000);
    end

    // P2C: plane 0 all pixels
    ctrl_write(0, 32'h1);
    data_write(0, 32'hFFFF);
    for (int k = 1; k < 8; k++) data_write(0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      data_read(0, "p2c_pl0", q);
      check_val("p2c_pl0_const", q, 32'h0101);
    end
    ctrl_write(0, 32'h0);

    // Write during drain restarts fill at word 0
    for (int k = 0; k < 8; k++) data_write(0, $urandom);
    for (int k = 0; k < 3; k++) data_read(0, "drain3", q);
    data_write(0, 32'h1234);
    ctrl_read(0, "abort_drain_ctrl", q);
    check_val("abort_drain_const", q, 32'h0100);
    data_read(0, "abort_drain_data", q);
    ctrl_write(0, 32'h2);

    // Single-lane write ignored
    bus_op(0, A_DATA, 1'b1, 1'b0, 1'b1, 1'b0, 32'hABCD, q);
    ctrl_read(0, "half_write_ctrl", q);

    // Asynchronous reset in mid-fill
    for (int k = 0; k < 5; k++) data_write(0, $urandom);
    pulse_reset();
    ctrl_read(0, "midfill_reset_ctrl", q);
    check_val("midfill_reset_ctrl_const", q, 32'h0);
    data_read(0, "midfill_reset_data", q);
    check_val("midfill_reset_data_const", q, 32'h0);
    ctrl_write(0, 32'h2);

    // 32-bit bus: pixel 31 plane 7, then overflow write
    for (int k = 0; k < 7; k++) data_write(1, 32'h0);
    data_write(1, 32'h0000_0080);
    data_write(1, 32'hFFFF_FFFF);
    ctrl_read(1, "w32_full_ctrl", q);
    check_val("w32_full_const", q, 32'h0500);
    for (int k = 0; k < 8; k++) begin
      data_read(1, "w32_read", q);
      check_val("w32_read_const", q, (k == 7) ? 32'h1 : 32'h0);
    end

    // Randomised traffic across all three geometries
    for (int n = 0; n < 900; n++) begin
      int w, op;
      logic [31:0] d, exp;
      w = $urandom_range(0, NI - 1);
      op = $urandom_range(0, 99);
      d = $urandom;
      if (op < 40) begin
        data_write(w, d);
      end else if (op < 74) begin
        data_read(w, "rnd_data", q);
      end else if (op < 82) begin
        ctrl_read(w, "rnd_ctrl", q);
      end else if (op < 86) begin
        ctrl_write(w, {30'h0, ($urandom_range(0, 3) == 0), d[0]});
      end else if (op < 91) begin
        exp = model_read_exp(w);
        bus_op(w, A_DATA, 1'b1, 1'b1, 1'b1, 1'b1, fit(w, d), q);
        check_val("rnd_wr_rd", q, exp);
        model_write(w, fit(w, d));
      end else if (op < 95) begin
        bus_op(w, A_DATA, 1'b1, 1'b0, d[0], ~d[0], fit(w, d), q);
      end else if (op < 98) begin
        bus_op(w, A_DATA, 1'b0, 1'b1, 1'b0, 1'b0, '0, q);
        check_val("rnd_unsel", q, 32'h0);
      end else begin
        bus_op(w, A_OTHER, 1'b1, 1'b1, 1'b0, 1'b0, '0, q);
        check_val("rnd_other_addr", q, 32'h0);
      end
    end

    for (int w = 0; w < NI; w++) ctrl_read(w, "final_ctrl", q);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/akiko_c2p_ext.md
Name: akiko_c2p_ext

Overview:
Parametrised chunky-to-planar / planar-to-chunky converter for the Akiko register window at $B8xxxx.
- The CPU writes a block of words in one format into an internal bit matrix (PIXELS x PLANES), then reads the block back, transposed, in the other format.
- Generalises the 16-bit C2P register with configurable bus width, pixel count and plane count, a P2C mode, an explicit FILL/DRAIN state machine, and a control/status register.
- Sits on the chipset register bus beside the other $B8 decodes.

Parameters:
DATA_W, 16, bus word width in bits (16 or 32).
PIXELS, 16, pixels per block (multiple of DATA_W).
PLANES, 8, bitplanes per pixel (1..8).

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
address_in  in  23  CPU word address [23:1].
data_in  in  DATA_W  write data.
data_out  out  DATA_W  read data; 0 when not selected.
rd  in  1  one-clock read strobe.
hwr  in  1  one-clock upper-byte write strobe.
lwr  in  1  one-clock lower-byte write strobe.
sel_akiko  in  1  $B8xxxx decode.

Behaviour:
- W = PIXELS*PLANES/DATA_W words per block.
- Defaults give W = 8.
- Decodes, both gated by sel_akiko:
  - DATA when address_in[7:2]==6'b001110 (0x38/0x3A).
  - CTRL when address_in[7:2]==6'b001100 (0x30/0x32).
- Writes take effect only when hwr && lwr; single-lane writes are ignored.
- Write beats read: if a write and rd are active in the same cycle, the write is processed and the read is a no-op apart from data_out.
- Reset (asynchronous, any state, including mid-FILL or mid-DRAIN):
  - state=IDLE, wrptr=0, rdptr=0, mode=0.
  - Buffer cleared to 0.
  - data_out=0.
- Buffer is a bit matrix b[pixel][plane].
- mode 0 = C2P:
  - Write word k holds pixels k*(DATA_W/PLANES).. in chunky order; the first pixel is in the MSB byte, and bit 0 of each byte is plane 0.
  - Read word r returns plane r/(PIXELS/DATA_W), pixel group r%(PIXELS/DATA_W).
  - data_out bit DATA_W-1-i = plane bit of pixel group*DATA_W+i.
  - Plane 0 is read first.
- mode 1 = P2C: exact inverse. Writes are planar (plane-major, plane 0 first); reads return chunky words.
- DATA read latency: data_out is combinational in the rd cycle, from rdptr. Pointers update on the following clk edge.
- State IDLE:
  - DATA write: store word 0, wrptr<=1, go to FILL.
  - DATA read: return word 0, rdptr<=1, go to DRAIN. Re-reads the current buffer.
- State FILL:
  - DATA write with wrptr<W: store word wrptr, wrptr++.
  - DATA write with wrptr==W: ignored (no wrap).
  - DATA read: wrptr<=0, return word 0, rdptr<=1, go to DRAIN. Unwritten words keep prior contents.
- State DRAIN:
  - DATA read: return word rdptr, rdptr++.
  - On the W-th read: rdptr<=0, go to IDLE.
  - DATA write: abort drain, rdptr<=0, store word 0, wrptr<=1, go to FILL.
- CTRL write:
  - bit0 = new mode.
  - bit1 = abort: state IDLE, pointers 0, buffer kept.
  - A mode change while not IDLE implies abort.
- CTRL read:
  - bit0 = mode.
  - bit8 = (state==FILL).
  - bit9 = (state==DRAIN).
  - bit10 = (wrptr==W).
  - All other bits 0.
  - No side effects.
- Unselected or non-read cycles: data_out = 0.

Decomposition:
- Shared package akiko_pkg holds:
  - The state enum (IDLE, FILL, DRAIN).
  - Register offset constants (DATA=6'b001110, CTRL=6'b001100).
  - MODE_C2P/MODE_P2C.
  - CTRL bit indices.
- One natural sub-module, akiko_xpose_mux: combinational word selector.
  - Inputs: buffer, mode, rdptr.
  - Output: one DATA_W read word.
  - Parametrised like the top level.
- The top level keeps the FSM, pointers, buffer write logic and decode.

Test Plan:
- Defaults, C2P: write 0x0101 x8, read 8 -> 0xFFFF, then 0x0000 x7. CTRL reads 0x0000 afterwards (IDLE).
- Defaults, C2P: write 0xFF00 then 0x0000 x7 -> all 8 reads return 0x8000.
- Defaults, P2C: CTRL write 0x0001. Write 0xFFFF then 0x0000 x7 -> 8 reads return 0x0101.
- Write 8 words, read 3, write 0x1234 -> CTRL read 0x0100 (FILL). The next read returns a word built from 0x1234 in word 0.
- Write 5 words, assert reset_n=0 for one cycle (no clk edge needed) -> CTRL read 0x0000. A subsequent read returns 0x0000.
- DATA_W=32, PIXELS=32: write 0x00000000 x7, then 0x00000080 -> reads 0..6 = 0, read 7 (plane 7) = 0x00000001. A 9th write before reading is ignored, and CTRL bit10=1.
